// File: rtl/fc_acc_sequencer_if.sv
// ---------------------------------------------------------------------------
// fc_acc_sequencer_if
// Handshake and buffer/bank control bundle between the FC accumulator-bank
// sequencer and its surroundings (layer controller, operand buffers, bank).
//
//   start        layer controller -> sequencer : begin a pass
//   abort        layer controller -> sequencer : cancel the current pass
//   src_valid    operand buffers  -> sequencer : operand pair available
//   out_ack      layer controller -> sequencer : results consumed
//   rd_en        sequencer -> buffers : fetch operand pair at rd_addr
//   rd_addr      sequencer -> buffers : current operand index
//   bias_sel     sequencer -> bank    : load bias into all accumulators
//   enable_write sequencer -> bank    : accumulate bank inputs
//   busy         sequencer -> ctrl    : a pass is in progress
//   out_valid    sequencer -> ctrl    : accumulator outputs are final
//
// Modport master is the sequencer side; slave is the environment side.
// ---------------------------------------------------------------------------
interface fc_acc_sequencer_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  start;
  logic                  abort;
  logic                  src_valid;
  logic                  out_ack;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  bias_sel;
  logic                  enable_write;
  logic                  busy;
  logic                  out_valid;

  modport master (
    input  start, abort, src_valid, out_ack,
    output rd_en, rd_addr, bias_sel, enable_write, busy, out_valid
  );

  modport slave (
    output start, abort, src_valid, out_ack,
    input  rd_en, rd_addr, bias_sel, enable_write, busy, out_valid
  );
endinterface

// File: rtl/fc_acc_sequencer.sv
// ---------------------------------------------------------------------------
// fc_acc_sequencer
// Sequences one output-neuron pass of the 10-lane FC register-accumulator
// bank: a single bias-load cycle, N_INPUTS operand fetches (stallable by
// src_valid), a write-enable stream delayed by MAC_LATENCY to line up with
// the MAC products, and a result handshake with the layer controller.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : fc_acc_sequencer_if.master (start/abort/src_valid/out_ack in;
//            rd_en/rd_addr/bias_sel/enable_write/busy/out_valid out)
//
// Parameters
//   N_INPUTS    : operand pairs per pass (>= 2)
//   ADDR_WIDTH  : width of rd_addr, 2**ADDR_WIDTH >= N_INPUTS
//   MAC_LATENCY : cycles from rd_en to product at the accumulators (>= 1)
// ---------------------------------------------------------------------------
module fc_acc_sequencer #(
  parameter int N_INPUTS    = 84,
  parameter int ADDR_WIDTH  = 7,
  parameter int MAC_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fc_acc_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_INPUTS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  logic [MAC_LATENCY-1:0] r_pipe;
  logic                   r_bias_sel;
  logic                   r_out_valid;
  logic                   r_busy;

  logic                   w_rd_en;
  logic                   w_last;

  // Fetch is combinational so a stalled source never costs a cycle.
  assign w_rd_en = (r_state == RUN) && bus.src_valid;
  assign w_last  = (r_rd_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rd_addr   <= '0;
      r_pipe      <= '0;
      r_bias_sel  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Valid pipe: one bit per MAC stage, bubbles preserved.
      r_pipe[0] <= w_rd_en;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      // bias_sel is a one-cycle pulse raised only on IDLE->BIAS.
      r_bias_sel <= 1'b0;

      if (bus.abort && (r_state != IDLE)) begin
        // Abort overrides everything, including the pipe shift above.
        r_state     <= IDLE;
        r_pipe      <= '0;
        r_rd_addr   <= '0;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            // abort in IDLE also blocks a simultaneous start.
            if (bus.start && !bus.abort) begin
              r_state    <= BIAS;
              r_bias_sel <= 1'b1;
              r_rd_addr  <= '0;
              r_busy     <= 1'b1;
            end
          end
          BIAS: begin
            r_state <= RUN;
          end
          RUN: begin
            if (w_rd_en) begin
              if (w_last) begin
                r_rd_addr <= '0;
                r_state   <= DRAIN;
              end else begin
                r_rd_addr <= r_rd_addr + ADDR_ONE;
              end
            end
          end
          DRAIN: begin
            // All products have been written once the pipe is empty.
            if (r_pipe == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
          DONE: begin
            if (bus.out_ack) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_en        = w_rd_en;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.bias_sel     = r_bias_sel;
  assign bus.enable_write = r_pipe[MAC_LATENCY-1];
  assign bus.busy         = r_busy;
  assign bus.out_valid    = r_out_valid;

endmodule

// File: doc/fc_acc_sequencer.md
Name: fc_acc_sequencer

Overview:
Controller for the 10-lane FC register-accumulator bank. It sequences one output-neuron pass:
- one bias-load cycle;
- N_INPUTS operand fetches from the input/weight buffers;
- a MAC-latency-delayed write-enable stream into the accumulators;
- a result handshake back to the layer controller.

It drives the bank's bias_sel and enable_write and owns the buffer read address.

Parameters:
N_INPUTS, 84, number of input activations per pass (≥2)
ADDR_WIDTH, 7, width of rd_addr; 2**ADDR_WIDTH ≥ N_INPUTS
MAC_LATENCY, 2, cycles from rd_en to the matching product at accumulator inputs (≥1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
start  in  1  pulse/level; begin a pass (sampled only in IDLE)
abort  in  1  synchronous cancel of the current pass
src_valid  in  1  input/weight buffers have an operand pair available this cycle
rd_en  out  1  fetch operand pair at rd_addr (combinational: state==RUN & src_valid)
rd_addr  out  ADDR_WIDTH  current operand index, registered
bias_sel  out  1  load bias into all accumulators, registered
enable_write  out  1  accumulate bank inputs, registered
busy  out  1  state != IDLE
out_valid  out  1  accumulator outputs final, held until out_ack
out_ack  in  1  consumer has taken results

Behaviour:
- Reset: asynchronous, active-low. While reset=0:
  - state=IDLE; rd_addr=0;
  - valid pipe (MAC_LATENCY bits) cleared;
  - bias_sel=0, enable_write=0, out_valid=0, busy=0.
  - A reset mid-pass discards in-flight fetches; no enable_write follows release.
- IDLE: start=1 → BIAS. Otherwise hold.
- BIAS: exactly one cycle.
  - bias_sel=1 for that cycle; rd_addr=0.
  - Next state RUN.
  - The pipe is guaranteed empty, so bias_sel and enable_write are never high together.
- RUN:
  - rd_en=src_valid. Each cycle with rd_en=1, rd_addr increments.
  - On the fetch with rd_addr==N_INPUTS-1, rd_addr wraps to 0 and state → DRAIN.
  - src_valid=0 stalls: rd_addr holds and no fetch occurs. Stalls of any length are legal.
- Valid pipe:
  - pipe[0]<=rd_en; pipe[i]<=pipe[i-1].
  - enable_write is pipe[MAC_LATENCY-1], so enable_write is rd_en delayed exactly MAC_LATENCY cycles, preserving bubbles.
  - Total enable_write pulses per pass equal N_INPUTS.
- DRAIN:
  - Waits until the pipe is all-zero, i.e. the cycle after the last enable_write.
  - Then → DONE and out_valid<=1.
- DONE:
  - out_valid=1 held.
  - out_ack=1 → IDLE; out_valid drops on the same edge.
  - start is ignored until IDLE is reached.
  - out_ack outside DONE is ignored.
- abort=1 in any non-IDLE state:
  - next state IDLE; pipe cleared; rd_addr=0; out_valid=0.
  - abort has priority over all other transitions.
  - abort in IDLE is a no-op, and also blocks a simultaneous start.
- Simultaneous events:
  - start with out_ack in DONE: go to IDLE; a new pass needs start in IDLE.
  - src_valid on the last fetch plus abort: abort wins; no further enable_write.
- Latency, no stalls: start sampled at edge 0.
  - Edge 1: bias_sel=1 for one cycle.
  - Fetches occur in cycles 2..N_INPUTS+1.
  - enable_write runs in cycles 2+L..N_INPUTS+1+L, where L=MAC_LATENCY.
  - out_valid rises at edge N_INPUTS+2+L.
- busy is registered from state, with no glitches.

Test Plan:
1. N_INPUTS=4, L=2, src_valid=1, single start pulse:
   - bias_sel high for 1 cycle;
   - rd_addr 0,1,2,3;
   - enable_write high for exactly 4 consecutive cycles, starting 2 cycles after the first rd_en;
   - out_valid rises 1 cycle after the last enable_write.
2. Same config, src_valid pattern 1,0,0,1,1,0,1:
   - enable_write reproduces the pattern shifted by 2 cycles;
   - 4 total pulses; rd_addr holds during the zeros.
3. Hold out_ack=0 for 10 cycles in DONE, with a start pulse mid-wait:
   - out_valid stays 1; no bias_sel;
   - out_ack=1 → IDLE and out_valid=0;
   - the next start launches a fresh pass with rd_addr=0.
4. abort asserted on the 3rd fetch cycle:
   - the next cycle shows busy=0 and rd_addr=0;
   - no enable_write pulses after the abort edge; out_valid never rises.
5. reset low for 1 cycle during DRAIN with the pipe non-empty:
   - all outputs 0 immediately (asynchronous);
   - after release, no stray enable_write; IDLE awaits start.
6. Back-to-back passes, N_INPUTS=84, L=3, src_valid=1, start re-asserted right after out_ack:
   - each pass gives exactly 1 bias_sel and 84 enable_write;
   - bias_sel and enable_write never overlap.
